// File: rtl/rename_pkg.sv
// rename_pkg: widths, register-index types and constants shared by the rename stage.
package rename_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int ARCH_ADDR_LEN = 5;
    localparam int NUM_PHYS_REGS = 64;
    localparam int PHYS_ADDR_LEN = 6;
    typedef logic [ARCH_ADDR_LEN-1:0] arch_reg_t;
    typedef logic [PHYS_ADDR_LEN-1:0] phys_reg_t;
    typedef phys_reg_t [NUM_ARCH_REGS-1:0] rat_t;
    localparam phys_reg_t P0 = '0;
endpackage

// File: rtl/map_table.sv
// map_table: arch-to-phys map with three async read ports, one write port and a whole-table restore load.
module map_table
    import rename_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  arch_reg_t [2:0] rd_addr,
    output phys_reg_t [2:0] rd_data,
    input  logic            we,
    input  arch_reg_t       waddr,
    input  phys_reg_t       wdata,
    input  logic            load,
    input  rat_t            load_data,
    output rat_t            map_q
);
    rat_t map;
    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i)
            for (int i = 0; i < NUM_ARCH_REGS; i++) map[i] <= phys_reg_t'(i);
        else if (load)
            map <= load_data;
        else if (we && waddr != '0)
            map[waddr] <= wdata;
    // x0 always reads p0 regardless of table contents
    always_comb
        for (int i = 0; i < 3; i++) rd_data[i] = (rd_addr[i] == '0) ? P0 : map[rd_addr[i]];
    assign map_q = map;
endmodule

// File: rtl/rename_unit.sv
// rename_unit: decode-to-ROB rename stage with speculative and committed RATs and flush restore.
module rename_unit
    import rename_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_pc_i,
    input  arch_reg_t   in_rd_i,
    input  arch_reg_t   in_rs1_i,
    input  arch_reg_t   in_rs2_i,
    input  logic        in_rd_we_i,
    input  logic        fl_empty_i,
    input  phys_reg_t   fl_alloc_addr_i,
    output logic        fl_pop_en_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output arch_reg_t   out_rd_o,
    output logic        out_rd_we_o,
    output phys_reg_t   out_prd_o,
    output phys_reg_t   out_old_prd_o,
    output phys_reg_t   out_prs1_o,
    output phys_reg_t   out_prs2_o,
    input  logic        commit_en_i,
    input  arch_reg_t   commit_rd_i,
    input  phys_reg_t   commit_prd_i,
    input  logic        flush_i
);
    logic need_alloc, accept, commit_we;
    phys_reg_t [2:0] spec_rd;
    phys_reg_t [2:0] comm_rd_unused;
    rat_t comm_map, restore_map, spec_map_unused;

    assign need_alloc  = in_rd_we_i && in_rd_i != '0;
    assign in_ready_o  = (!out_valid_o || out_ready_i) && !flush_i && !(need_alloc && fl_empty_i);
    assign accept      = in_valid_i && in_ready_o;
    assign fl_pop_en_o = accept && need_alloc && reset_i;
    assign commit_we   = commit_en_i && commit_rd_i != '0;

    // restore image includes a commit landing in the same cycle as the flush
    always_comb begin
        restore_map = comm_map;
        if (commit_we) restore_map[commit_rd_i] = commit_prd_i;
    end

    map_table u_spec (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rd_addr   ({in_rd_i, in_rs2_i, in_rs1_i}),
        .rd_data   (spec_rd),
        .we        (accept && need_alloc),
        .waddr     (in_rd_i),
        .wdata     (fl_alloc_addr_i),
        .load      (flush_i),
        .load_data (restore_map),
        .map_q     (spec_map_unused)
    );

    map_table u_comm (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rd_addr   ('0),
        .rd_data   (comm_rd_unused),
        .we        (commit_we),
        .waddr     (commit_rd_i),
        .wdata     (commit_prd_i),
        .load      (1'b0),
        .load_data ('0),
        .map_q     (comm_map)
    );

    always_ff @(posedge clk_i or negedge reset_i)
        if (!reset_i) begin
            out_valid_o   <= 1'b0;
            out_pc_o      <= '0;
            out_rd_o      <= '0;
            out_rd_we_o   <= 1'b0;
            out_prd_o     <= P0;
            out_old_prd_o <= P0;
            out_prs1_o    <= P0;
            out_prs2_o    <= P0;
        end else if (accept) begin
            out_valid_o   <= 1'b1;
            out_pc_o      <= in_pc_i;
            out_rd_o      <= in_rd_i;
            out_rd_we_o   <= need_alloc;
            out_prd_o     <= need_alloc ? fl_alloc_addr_i : P0;
            out_old_prd_o <= spec_rd[2];
            out_prs1_o    <= spec_rd[0];
            out_prs2_o    <= spec_rd[1];
        end else if (out_ready_i || flush_i)
            out_valid_o   <= 1'b0;
endmodule

// File: tb/tb_rename_unit.sv
// tb_rename_unit: directed plan cases plus randomized traffic against a RAT/free-list/ROB reference model.
module tb_rename_unit;
    logic        clk_i = 0, reset_i = 1, in_valid_i = 0, in_ready_o, in_rd_we_i = 0, fl_empty_i = 0;
    logic [31:0] in_pc_i = 0, out_pc_o;
    logic [4:0]  in_rd_i = 0, in_rs1_i = 0, in_rs2_i = 0, out_rd_o, commit_rd_i = 0;
    logic [5:0]  fl_alloc_addr_i = 0, out_prd_o, out_old_prd_o, out_prs1_o, out_prs2_o, commit_prd_i = 0;
    logic        fl_pop_en_o, out_valid_o, out_ready_i = 0, out_rd_we_o, commit_en_i = 0, flush_i = 0;

    typedef struct packed {
        logic v; logic [31:0] pc; logic [4:0] rd; logic we;
        logic [5:0] prd, old, p1, p2;
    } out_t;

    logic [5:0] spec_m [32];
    logic [5:0] comm_m [32];
    out_t eo, prev, head;
    out_t rob [$];
    logic [5:0] fl [$];
    int passed = 0, total = 0;
    bit acc, dc, hs;

    rename_unit dut (
        .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i),
        .in_rd_we_i(in_rd_we_i), .fl_empty_i(fl_empty_i), .fl_alloc_addr_i(fl_alloc_addr_i),
        .fl_pop_en_o(fl_pop_en_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_rd_o(out_rd_o), .out_rd_we_o(out_rd_we_o), .out_prd_o(out_prd_o),
        .out_old_prd_o(out_old_prd_o), .out_prs1_o(out_prs1_o), .out_prs2_o(out_prs2_o),
        .commit_en_i(commit_en_i), .commit_rd_i(commit_rd_i), .commit_prd_i(commit_prd_i),
        .flush_i(flush_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin spec_m[i] = 6'(i); comm_m[i] = 6'(i); end
        eo = '0;
        rob.delete();
        fl.delete();
        for (int i = 32; i < 64; i++) fl.push_back(6'(i));
    endtask

    task automatic do_reset();
        reset_i = 0; in_valid_i = 1; in_rd_we_i = 1; in_rd_i = 5; fl_empty_i = 0;
        out_ready_i = 1; flush_i = 0; commit_en_i = 0;
        #1;
        model_reset();
        check("rst_valid", out_valid_o, 0);
        check("rst_pc", out_pc_o, 0);
        check("rst_rd", out_rd_o, 0);
        check("rst_we", out_rd_we_o, 0);
        check("rst_prd", out_prd_o, 0);
        check("rst_old", out_old_prd_o, 0);
        check("rst_prs", {out_prs1_o, out_prs2_o}, 0);
        check("rst_pop", fl_pop_en_o, 0);
        @(negedge clk_i);
        reset_i = 1; in_valid_i = 0;
    endtask

    // settle, check handshake, advance model by one edge, then check registered outputs
    task automatic cycle(output bit a);
        bit na, rdy;
        out_t n;
        #1;
        na = in_rd_we_i && in_rd_i != 0;
        rdy = (!eo.v || out_ready_i) && !flush_i && !(na && fl_empty_i);
        a = in_valid_i && rdy;
        check("in_ready", in_ready_o, rdy);
        check("pop", fl_pop_en_o, a && na);
        n = eo;
        if (a) begin
            n.v = 1; n.pc = in_pc_i; n.rd = in_rd_i; n.we = na;
            n.prd = na ? fl_alloc_addr_i : 6'd0;
            n.old = spec_m[in_rd_i]; n.p1 = spec_m[in_rs1_i]; n.p2 = spec_m[in_rs2_i];
        end else if (flush_i || out_ready_i) n.v = 0;
        if (a && na) spec_m[in_rd_i] = fl_alloc_addr_i;
        if (commit_en_i && commit_rd_i != 0) comm_m[commit_rd_i] = commit_prd_i;
        if (flush_i) spec_m = comm_m;
        eo = n;
        @(posedge clk_i);
        @(negedge clk_i);
        check("out_valid", out_valid_o, eo.v);
        if (eo.v) begin
            check("out_pc", out_pc_o, eo.pc);
            check("out_rd", {out_rd_o, out_rd_we_o}, {eo.rd, eo.we});
            check("out_prd", out_prd_o, eo.prd);
            check("out_old", out_old_prd_o, eo.old);
            check("out_prs", {out_prs1_o, out_prs2_o}, {eo.p1, eo.p2});
        end
    endtask

    task automatic set_in(bit v, int rd, int rs1, int rs2, bit we, int alloc, bit empty, bit ordy);
        in_valid_i = v; in_rd_i = 5'(rd); in_rs1_i = 5'(rs1); in_rs2_i = 5'(rs2);
        in_rd_we_i = we; fl_alloc_addr_i = 6'(alloc); fl_empty_i = empty; out_ready_i = ordy;
        in_pc_i = $urandom;
    endtask

    task automatic rand_drive(output bit do_commit, output out_t h);
        in_valid_i = $urandom_range(0, 3) != 0;
        in_pc_i = $urandom;
        in_rd_i = 5'($urandom_range(0, 7));
        in_rs1_i = 5'($urandom_range(0, 7));
        in_rs2_i = 5'($urandom_range(0, 31));
        in_rd_we_i = $urandom_range(0, 4) != 0;
        fl_empty_i = fl.size() == 0 || $urandom_range(0, 15) == 0;
        fl_alloc_addr_i = fl.size() != 0 ? fl[0] : 6'($urandom);
        out_ready_i = $urandom_range(0, 9) < 7;
        flush_i = $urandom_range(0, 24) == 0;
        do_commit = rob.size() != 0 && $urandom_range(0, 2) == 0;
        h = do_commit ? rob[0] : '0;
        commit_en_i = do_commit ? h.we : ($urandom_range(0, 15) == 0);
        commit_rd_i = do_commit ? h.rd : 5'd0;
        commit_prd_i = do_commit ? h.prd : 6'($urandom);
    endtask

    initial begin
        #2;
        do_reset();
        // first rename, rs1 == rd sees old mapping
        set_in(1, 5, 5, 0, 1, 32, 0, 1);
        #1 check("t1_pop", fl_pop_en_o, 1);
        cycle(acc);
        check("t1_prs1", out_prs1_o, 5);
        check("t1_prs2", out_prs2_o, 0);
        check("t1_old", out_old_prd_o, 5);
        check("t1_prd", out_prd_o, 32);
        set_in(1, 5, 0, 0, 1, 33, 0, 1);
        cycle(acc);
        check("t2_old", out_old_prd_o, 32);
        check("t2_prd", out_prd_o, 33);
        set_in(1, 0, 5, 0, 0, 0, 0, 1);
        cycle(acc);
        check("t2_rs1", out_prs1_o, 33);
        // empty free list only stalls instructions that need a register
        set_in(1, 7, 0, 0, 1, 34, 1, 1);
        #1 check("t3_stall", {in_ready_o, fl_pop_en_o}, 2'b00);
        cycle(acc);
        check("t3_drained", out_valid_o, 0);
        set_in(1, 0, 0, 0, 1, 34, 1, 1);
        #1 check("t3_rd0_ready", in_ready_o, 1);
        cycle(acc);
        check("t3_rd0_prd", {out_valid_o, out_prd_o, out_rd_we_o}, {1'b1, 6'd0, 1'b0});
        set_in(1, 7, 0, 0, 0, 34, 1, 1);
        #1 check("t3_we0_ready", in_ready_o, 1);
        cycle(acc);
        check("t3_we0_prd", out_prd_o, 0);
        // backpressure hold then drain with same-cycle accept
        set_in(1, 6, 0, 0, 1, 34, 0, 1);
        cycle(acc);
        set_in(1, 8, 0, 0, 1, 35, 0, 0);
        repeat (3) begin
            #1 check("t4_hold_ready", {in_ready_o, fl_pop_en_o}, 2'b00);
            cycle(acc);
            check("t4_hold_prd", {out_valid_o, out_prd_o}, {1'b1, 6'd34});
        end
        out_ready_i = 1;
        cycle(acc);
        check("t4_next_prd", {out_valid_o, out_prd_o}, {1'b1, 6'd35});
        // flush restores committed mapping
        set_in(1, 3, 0, 0, 1, 40, 0, 1);
        cycle(acc);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        commit_en_i = 1; commit_rd_i = 3; commit_prd_i = 40;
        cycle(acc);
        commit_en_i = 0;
        set_in(1, 3, 0, 0, 1, 41, 0, 1);
        cycle(acc);
        set_in(1, 9, 0, 0, 1, 42, 0, 1);
        flush_i = 1;
        cycle(acc);
        check("t5_flush_valid", out_valid_o, 0);
        flush_i = 0;
        set_in(1, 0, 3, 0, 0, 0, 0, 1);
        cycle(acc);
        check("t5_rs1", out_prs1_o, 40);
        // flush with a concurrent commit forwards the commit
        set_in(1, 4, 0, 0, 1, 43, 0, 1);
        cycle(acc);
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        commit_en_i = 1; commit_rd_i = 4; commit_prd_i = 45; flush_i = 1;
        cycle(acc);
        commit_en_i = 0; flush_i = 0;
        set_in(1, 0, 4, 0, 0, 0, 0, 1);
        cycle(acc);
        check("t6_rs1", out_prs1_o, 45);
        // random traffic, reset once mid-run
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            rand_drive(dc, head);
            hs = eo.v && out_ready_i;
            prev = eo;
            cycle(acc);
            if (dc) begin
                void'(rob.pop_front());
                if (head.we) fl.push_back(head.old);
            end
            if (acc && in_rd_we_i && in_rd_i != 0) void'(fl.pop_front());
            if (flush_i) begin
                foreach (rob[i]) if (rob[i].we) fl.push_back(rob[i].prd);
                if (prev.v && prev.we) fl.push_back(prev.prd);
                rob.delete();
            end else if (hs) rob.push_back(prev);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage between decode and the ROB.
- Consumes physical registers from the free-list circular buffer and maintains a speculative register alias table (RAT) plus a committed RAT.
- Emits renamed instructions to the ROB, including the previous destination mapping so commit can push it back to the free list.
- On flush, restores the speculative RAT from the committed RAT.

Parameters:
- NUM_ARCH_REGS, 32, architectural registers; x0 is hard-wired and never renamed.
- ARCH_ADDR_LEN, 5, architectural register index width.
- NUM_PHYS_REGS, 64, physical registers.
- PHYS_ADDR_LEN, 6, physical register index width; must equal the free-list data width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  decoded instruction valid.
- in_ready_o  out  1  stage can accept this cycle.
- in_pc_i  in  32  instruction PC.
- in_rd_i / in_rs1_i / in_rs2_i  in  ARCH_ADDR_LEN each  architectural destination and sources.
- in_rd_we_i  in  1  instruction writes rd.
- fl_empty_i  in  1  free list empty.
- fl_alloc_addr_i  in  PHYS_ADDR_LEN  free-list head value, valid combinationally.
- fl_pop_en_o  out  1  pop the free list this cycle.
- out_valid_o  out  1  renamed instruction valid.
- out_ready_i  in  1  ROB/dispatch accepts.
- out_pc_o  out  32  PC.
- out_rd_o  out  ARCH_ADDR_LEN  architectural destination.
- out_rd_we_o  out  1  effective write enable (0 if rd==0).
- out_prd_o / out_old_prd_o / out_prs1_o / out_prs2_o  out  PHYS_ADDR_LEN each  new dest, previous dest mapping, source mappings.
- commit_en_i  in  1  ROB commits an instruction that writes rd.
- commit_rd_i  in  ARCH_ADDR_LEN  committed architectural destination.
- commit_prd_i  in  PHYS_ADDR_LEN  committed physical destination.
- flush_i  in  1  mispredict/exception flush.

Behaviour:
- Reset (reset_i=0, async):
  - Speculative and committed RAT entry i = i.
  - The free list must hold p32..p63; that initialisation is the integrator's responsibility.
  - out_valid_o=0, all other output registers 0.
  - fl_pop_en_o=0 while in reset.
- need_alloc = in_rd_we_i & (in_rd_i != 0).
- Ready and accept:
  - in_ready_o = (!out_valid_o | out_ready_i) & !flush_i & !(need_alloc & fl_empty_i).
  - in_ready_o depends on in_rd_i/in_rd_we_i by design.
  - accept = in_valid_i & in_ready_o.
  - fl_pop_en_o = accept & need_alloc, combinational.
- Latency 1 cycle. On accept, the output register loads on the next edge:
  - out_prs1_o/out_prs2_o = speculative RAT[rs] read before this cycle's write, so rs==rd sees the old mapping. x0 reads give p0.
  - out_old_prd_o = RAT[rd] (old mapping).
  - out_prd_o = fl_alloc_addr_i if need_alloc, else 0.
  - out_rd_we_o = need_alloc.
  - Speculative RAT[rd] <= fl_alloc_addr_i when need_alloc.
- Output handshake:
  - out_valid_o set on accept.
  - Cleared when out_ready_i & !accept.
  - Held with stable payload while out_valid_o & !out_ready_i.
- Commit: when commit_en_i and commit_rd_i != 0, committed RAT[commit_rd_i] <= commit_prd_i. Commit to x0 is ignored.
- Flush (synchronous, one cycle):
  - Speculative RAT <= committed RAT, with any same-cycle commit included (commit value forwarded).
  - out_valid_o <= 0.
  - No accept and no pop that cycle.
  - Returning squashed physical registers to the free list is out of scope; the ROB walk handles it.
- Simultaneous accept and commit (no flush) are independent and update different tables.
- Reset asserted mid-operation discards all in-flight state immediately.

Decomposition:
- Shared package rename_pkg holds:
  - ARCH_ADDR_LEN, PHYS_ADDR_LEN, NUM_ARCH_REGS, NUM_PHYS_REGS.
  - An arch-reg-index typedef and a phys-reg-index typedef.
  - The constant P0 = 0.
- Sub-module map_table, instantiated twice:
  - NUM_ARCH_REGS x PHYS_ADDR_LEN array.
  - 3 combinational read ports, 1 write port.
  - Whole-table parallel load input for restore.
  - Identity reset.
  - The committed instance leaves its read ports unused and exports the full table.

Test Plan:
- Reset, then rename rd=5 rs1=5 rs2=0 with we=1 and fl_alloc_addr_i=32 -> fl_pop_en_o=1; next cycle out_prs1_o=5, out_prs2_o=0, out_old_prd_o=5, out_prd_o=32.
- Back-to-back rd=5 writes with alloc 32 then 33 -> second instruction gets out_old_prd_o=32 and out_prd_o=33; a following reader of rs1=5 gets 33.
- fl_empty_i=1 with rd=7 we=1 -> in_ready_o=0 and no pop; the same cycle with rd=0 or we=0 -> in_ready_o=1 and out_prd_o=0.
- Hold out_ready_i=0 for 3 cycles while out_valid_o=1 -> payload stable, in_ready_o=0, no pops; release -> drains, next instruction accepted the same cycle.
- Rename rd=3 to p40, commit (3,p40), rename rd=3 to p41, assert flush_i -> out_valid_o=0; the next rename reading rs1=3 gets p40.
- Flush concurrent with commit (4,p45) -> the next read of rs1=4 returns p45.
